// File: rtl/axi4_lite_regfile.sv
// AXI4-Lite responder exposing NREGS byte-writable registers, with the register
// contents exported flat and a one-cycle strobe on every in-range commit.
module axi4_lite_regfile #(
    parameter int AWIDTH = 12,
    parameter int DWIDTH = 32,
    parameter int SWIDTH = DWIDTH / 8,
    parameter int NREGS  = 16
) (
    input  logic                      i_aClk,
    input  logic                      i_aReset,
    input  logic                      i_arValid,
    output logic                      o_arReady,
    input  logic [AWIDTH-1:0]         i_arAddr,
    input  logic [2:0]                i_arProt,
    output logic                      o_rValid,
    input  logic                      i_rReady,
    output logic [DWIDTH-1:0]         o_rData,
    output logic [1:0]                o_rResp,
    input  logic                      i_awValid,
    output logic                      o_awReady,
    input  logic [AWIDTH-1:0]         i_awAddr,
    input  logic [2:0]                i_awProt,
    input  logic                      i_wValid,
    output logic                      o_wReady,
    input  logic [DWIDTH-1:0]         i_wData,
    input  logic [SWIDTH-1:0]         i_wStrb,
    output logic                      o_bValid,
    input  logic                      i_bReady,
    output logic [1:0]                o_bResp,
    output logic [NREGS*DWIDTH-1:0]   o_regs,
    output logic                      o_wrStb,
    output logic [$clog2(NREGS)-1:0]  o_wrIdx
);

    localparam int BW = $clog2(SWIDTH);
    localparam int IW = $clog2(NREGS);
    localparam logic [AWIDTH:0] SPAN = (AWIDTH + 1)'(NREGS * SWIDTH);

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10
    } resp_e;

    logic [DWIDTH-1:0] regs_q [NREGS];
    logic [DWIDTH-1:0] regs_d [NREGS];
    logic              aw_held_q, aw_held_d;
    logic [AWIDTH-1:0] aw_addr_q, aw_addr_d;
    logic              w_held_q, w_held_d;
    logic [DWIDTH-1:0] w_data_q, w_data_d;
    logic [SWIDTH-1:0] w_strb_q, w_strb_d;
    logic              b_valid_q, b_valid_d;
    resp_e             b_resp_q, b_resp_d;
    logic              r_valid_q, r_valid_d;
    logic [DWIDTH-1:0] r_data_q, r_data_d;
    resp_e             r_resp_q, r_resp_d;
    logic              wr_stb_q, wr_stb_d;
    logic [IW-1:0]     wr_idx_q, wr_idx_d;

    logic          aw_hs, w_hs, ar_hs, commit;
    logic          aw_in_range, ar_in_range;
    logic [IW-1:0] aw_idx, ar_idx;
    logic          unused_prot;

    assign unused_prot = ^{i_arProt, i_awProt};

    assign o_awReady = ~i_aReset & ~aw_held_q;
    assign o_wReady  = ~i_aReset & ~w_held_q;
    assign o_arReady = ~i_aReset & ~r_valid_q;

    assign aw_hs = i_awValid & o_awReady;
    assign w_hs  = i_wValid & o_wReady;
    assign ar_hs = i_arValid & o_arReady;

    assign aw_idx      = aw_addr_q[BW +: IW];
    assign ar_idx      = i_arAddr[BW +: IW];
    assign aw_in_range = {1'b0, aw_addr_q} < SPAN;
    assign ar_in_range = {1'b0, i_arAddr} < SPAN;

    // A held pair may commit only when the B slot is free or being drained now.
    assign commit = aw_held_q & w_held_q & (~b_valid_q | i_bReady);

    // NOTE: every variable gets its hold value first, so no path leaves one unassigned (no latches).
    always_comb begin
        regs_d    = regs_q;
        aw_held_d = aw_held_q;
        aw_addr_d = aw_addr_q;
        w_held_d  = w_held_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        b_valid_d = b_valid_q;
        b_resp_d  = b_resp_q;
        r_valid_d = r_valid_q;
        r_data_d  = r_data_q;
        r_resp_d  = r_resp_q;
        wr_stb_d  = 1'b0;
        wr_idx_d  = wr_idx_q;

        if (aw_hs) begin
            aw_held_d = 1'b1;
            aw_addr_d = i_awAddr;
        end
        if (w_hs) begin
            w_held_d = 1'b1;
            w_data_d = i_wData;
            w_strb_d = i_wStrb;
        end

        if (commit) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            b_valid_d = 1'b1;
            b_resp_d  = aw_in_range ? RESP_OKAY : RESP_SLVERR;
            if (aw_in_range) begin
                wr_stb_d = 1'b1;
                wr_idx_d = aw_idx;
                for (int b = 0; b < SWIDTH; b++) begin
                    if (w_strb_q[b]) regs_d[aw_idx][8*b +: 8] = w_data_q[8*b +: 8];
                end
            end
        end else if (i_bReady) begin
            b_valid_d = 1'b0;
        end

        // Reads sample regs_q, so a same-edge commit is not yet visible.
        if (ar_hs) begin
            r_valid_d = 1'b1;
            r_data_d  = ar_in_range ? regs_q[ar_idx] : '0;
            r_resp_d  = ar_in_range ? RESP_OKAY : RESP_SLVERR;
        end else if (i_rReady) begin
            r_valid_d = 1'b0;
        end
    end

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_aClk) begin
        if (i_aReset) begin
            // NOTE: the register array is reset too, since fabric logic sees o_regs directly.
            regs_q    <= '{default: '0};
            aw_held_q <= 1'b0;
            aw_addr_q <= '0;
            w_held_q  <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            b_valid_q <= 1'b0;
            b_resp_q  <= RESP_OKAY;
            r_valid_q <= 1'b0;
            r_data_q  <= '0;
            r_resp_q  <= RESP_OKAY;
            wr_stb_q  <= 1'b0;
            wr_idx_q  <= '0;
        end else begin
            regs_q    <= regs_d;
            aw_held_q <= aw_held_d;
            aw_addr_q <= aw_addr_d;
            w_held_q  <= w_held_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            b_valid_q <= b_valid_d;
            b_resp_q  <= b_resp_d;
            r_valid_q <= r_valid_d;
            r_data_q  <= r_data_d;
            r_resp_q  <= r_resp_d;
            wr_stb_q  <= wr_stb_d;
            wr_idx_q  <= wr_idx_d;
        end
    end

    assign o_rValid = r_valid_q;
    assign o_rData  = r_data_q;
    assign o_rResp  = r_resp_q;
    assign o_bValid = b_valid_q;
    assign o_bResp  = b_resp_q;
    assign o_wrStb  = wr_stb_q;
    assign o_wrIdx  = wr_idx_q;

    for (genvar k = 0; k < NREGS; k++) begin : g_regs_out
        assign o_regs[k*DWIDTH +: DWIDTH] = regs_q[k];
    end

endmodule

// File: tb/tb_axi4_lite_regfile.sv
// Directed bench for axi4_lite_regfile: reset, write orderings, out-of-range,
// B stall, read/write collision and mid-transaction reset.
module tb_axi4_lite_regfile;

    localparam int AWIDTH = 12;
    localparam int DWIDTH = 32;
    localparam int SWIDTH = 4;
    localparam int NREGS  = 16;

    logic                     clk = 1'b0;
    logic                     i_aReset;
    logic                     i_arValid, o_arReady;
    logic [AWIDTH-1:0]        i_arAddr;
    logic [2:0]               i_arProt;
    logic                     o_rValid, i_rReady;
    logic [DWIDTH-1:0]        o_rData;
    logic [1:0]               o_rResp;
    logic                     i_awValid, o_awReady;
    logic [AWIDTH-1:0]        i_awAddr;
    logic [2:0]               i_awProt;
    logic                     i_wValid, o_wReady;
    logic [DWIDTH-1:0]        i_wData;
    logic [SWIDTH-1:0]        i_wStrb;
    logic                     o_bValid, i_bReady;
    logic [1:0]               o_bResp;
    logic [NREGS*DWIDTH-1:0]  o_regs;
    logic                     o_wrStb;
    logic [3:0]               o_wrIdx;

    logic [DWIDTH-1:0] exp_regs [NREGS];
    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    axi4_lite_regfile #(
        .AWIDTH(AWIDTH), .DWIDTH(DWIDTH), .SWIDTH(SWIDTH), .NREGS(NREGS)
    ) dut (
        .i_aClk(clk), .i_aReset(i_aReset),
        .i_arValid(i_arValid), .o_arReady(o_arReady), .i_arAddr(i_arAddr), .i_arProt(i_arProt),
        .o_rValid(o_rValid), .i_rReady(i_rReady), .o_rData(o_rData), .o_rResp(o_rResp),
        .i_awValid(i_awValid), .o_awReady(o_awReady), .i_awAddr(i_awAddr), .i_awProt(i_awProt),
        .i_wValid(i_wValid), .o_wReady(o_wReady), .i_wData(i_wData), .i_wStrb(i_wStrb),
        .o_bValid(o_bValid), .i_bReady(i_bReady), .o_bResp(o_bResp),
        .o_regs(o_regs), .o_wrStb(o_wrStb), .o_wrIdx(o_wrIdx)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_regs(input string tag);
        for (int k = 0; k < NREGS; k++)
            check($sformatf("%s_reg%0d", tag, k), 64'(o_regs[k*DWIDTH +: DWIDTH]), 64'(exp_regs[k]));
    endtask

    // Advance past the next rising edge; outputs are then stable for checking.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int k = 0; k < NREGS; k++) exp_regs[k] = '0;
        i_aReset  = 1'b1;
        i_arValid = 1'b0; i_arAddr = '0; i_arProt = 3'b000;
        i_awValid = 1'b0; i_awAddr = '0; i_awProt = 3'b000;
        i_wValid  = 1'b0; i_wData  = '0; i_wStrb  = '0;
        i_bReady  = 1'b1; i_rReady = 1'b1;
        tick; tick;

        // Reset state
        check("rst_awready", 64'(o_awReady), 64'd0);
        check("rst_wready",  64'(o_wReady),  64'd0);
        check("rst_arready", 64'(o_arReady), 64'd0);
        check("rst_rvalid",  64'(o_rValid),  64'd0);
        check("rst_bvalid",  64'(o_bValid),  64'd0);
        check("rst_wrstb",   64'(o_wrStb),   64'd0);
        check("rst_rdata",   64'(o_rData),   64'd0);
        check("rst_bresp",   64'(o_bResp),   64'd0);
        check("rst_rresp",   64'(o_rResp),   64'd0);
        check("rst_wridx",   64'(o_wrIdx),   64'd0);
        check_regs("rst");
        i_aReset = 1'b0;
        #1;
        check("post_rst_awready", 64'(o_awReady), 64'd1);
        check("post_rst_arready", 64'(o_arReady), 64'd1);

        // 1: AW and W in the same cycle to 0x004
        i_awValid = 1'b1; i_awAddr = 12'h004;
        i_wValid  = 1'b1; i_wData  = 32'hDEADBEEF; i_wStrb = 4'hF;
        tick;
        i_awValid = 1'b0; i_wValid = 1'b0;
        check("t1_bvalid_early", 64'(o_bValid),  64'd0);
        check("t1_awready_held", 64'(o_awReady), 64'd0);
        tick;
        exp_regs[1] = 32'hDEADBEEF;
        check("t1_bvalid", 64'(o_bValid), 64'd1);
        check("t1_bresp",  64'(o_bResp),  64'd0);
        check("t1_wrstb",  64'(o_wrStb),  64'd1);
        check("t1_wridx",  64'(o_wrIdx),  64'd1);
        check("t1_reg1",   64'(o_regs[1*DWIDTH +: DWIDTH]), 64'(exp_regs[1]));
        tick;
        check("t1_bvalid_done", 64'(o_bValid), 64'd0);
        check("t1_wrstb_pulse", 64'(o_wrStb),  64'd0);
        i_arValid = 1'b1; i_arAddr = 12'h004; i_rReady = 1'b0;
        tick;
        i_arValid = 1'b0;
        check("t1_rvalid",  64'(o_rValid),  64'd1);
        check("t1_rdata",   64'(o_rData),   64'hDEADBEEF);
        check("t1_rresp",   64'(o_rResp),   64'd0);
        check("t1_arready", 64'(o_arReady), 64'd0);
        tick;
        check("t1_rvalid_hold", 64'(o_rValid), 64'd1);
        check("t1_rdata_hold",  64'(o_rData),  64'hDEADBEEF);
        i_rReady = 1'b1;
        tick;
        check("t1_rvalid_done", 64'(o_rValid), 64'd0);

        // 2: W three cycles before AW, partial strobes
        i_wValid = 1'b1; i_wData = 32'h11223344; i_wStrb = 4'h5;
        tick;
        i_wValid = 1'b0;
        check("t2_wready_held", 64'(o_wReady), 64'd0);
        tick; tick;
        check("t2_wready_still", 64'(o_wReady), 64'd0);
        check("t2_no_bvalid",    64'(o_bValid), 64'd0);
        i_awValid = 1'b1; i_awAddr = 12'h008;
        tick;
        i_awValid = 1'b0;
        tick;
        exp_regs[2] = 32'h00220044;
        check("t2_bvalid", 64'(o_bValid), 64'd1);
        check("t2_bresp",  64'(o_bResp),  64'd0);
        check("t2_wridx",  64'(o_wrIdx),  64'd2);
        check("t2_reg2",   64'(o_regs[2*DWIDTH +: DWIDTH]), 64'(exp_regs[2]));
        tick;

        // 3: out-of-range write and read at 0x040
        i_awValid = 1'b1; i_awAddr = 12'h040;
        i_wValid  = 1'b1; i_wData  = 32'hFFFFFFFF; i_wStrb = 4'hF;
        tick;
        i_awValid = 1'b0; i_wValid = 1'b0;
        tick;
        check("t3_bvalid", 64'(o_bValid), 64'd1);
        check("t3_bresp",  64'(o_bResp),  64'd2);
        check("t3_wrstb",  64'(o_wrStb),  64'd0);
        check_regs("t3");
        tick;
        i_arValid = 1'b1; i_arAddr = 12'h040;
        tick;
        i_arValid = 1'b0;
        check("t3_rvalid", 64'(o_rValid), 64'd1);
        check("t3_rdata",  64'(o_rData),  64'd0);
        check("t3_rresp",  64'(o_rResp),  64'd2);
        tick;

        // 4: B stall with a second pair queued behind it
        i_bReady  = 1'b0;
        i_awValid = 1'b1; i_awAddr = 12'h010;
        i_wValid  = 1'b1; i_wData  = 32'h12345678; i_wStrb = 4'hF;
        tick;
        i_awValid = 1'b0; i_wValid = 1'b0;
        tick;
        exp_regs[4] = 32'h12345678;
        check("t4_bvalid1", 64'(o_bValid), 64'd1);
        check("t4_bresp1",  64'(o_bResp),  64'd0);
        check("t4_wridx1",  64'(o_wrIdx),  64'd4);
        i_awValid = 1'b1; i_awAddr = 12'h044;
        i_wValid  = 1'b1; i_wData  = 32'hCAFEBABE; i_wStrb = 4'hF;
        tick;
        i_awValid = 1'b0; i_wValid = 1'b0;
        check("t4_awready_full", 64'(o_awReady), 64'd0);
        check("t4_wready_full",  64'(o_wReady),  64'd0);
        tick; tick; tick;
        check("t4_bvalid_stall", 64'(o_bValid), 64'd1);
        check("t4_bresp_stall",  64'(o_bResp),  64'd0);
        check("t4_no_wrstb",     64'(o_wrStb),  64'd0);
        i_bReady = 1'b1;
        tick;
        check("t4_bvalid2",  64'(o_bValid),  64'd1);
        check("t4_bresp2",   64'(o_bResp),   64'd2);
        check("t4_awready2", 64'(o_awReady), 64'd1);
        check("t4_wready2",  64'(o_wReady),  64'd1);
        tick;
        check("t4_bvalid_done", 64'(o_bValid), 64'd0);
        check_regs("t4");

        // 5: read and commit to 0x00C on the same edge
        i_awValid = 1'b1; i_awAddr = 12'h00C;
        i_wValid  = 1'b1; i_wData  = 32'h00000001; i_wStrb = 4'hF;
        tick;
        i_awValid = 1'b0; i_wValid = 1'b0;
        tick; tick;
        exp_regs[3] = 32'h00000001;
        check("t5_reg3_pre", 64'(o_regs[3*DWIDTH +: DWIDTH]), 64'(exp_regs[3]));
        i_awValid = 1'b1; i_awAddr = 12'h00C;
        i_wValid  = 1'b1; i_wData  = 32'hA5A5A5A5; i_wStrb = 4'hF;
        tick;
        i_awValid = 1'b0; i_wValid = 1'b0;
        i_arValid = 1'b1; i_arAddr = 12'h00C;
        tick;
        i_arValid = 1'b0;
        exp_regs[3] = 32'hA5A5A5A5;
        check("t5_rvalid",  64'(o_rValid), 64'd1);
        check("t5_rdata_old", 64'(o_rData), 64'h00000001);
        check("t5_bvalid",  64'(o_bValid), 64'd1);
        check("t5_reg3_new", 64'(o_regs[3*DWIDTH +: DWIDTH]), 64'(exp_regs[3]));
        tick;
        i_arValid = 1'b1; i_arAddr = 12'h00C;
        tick;
        i_arValid = 1'b0;
        check("t5_rdata_new", 64'(o_rData), 64'hA5A5A5A5);
        tick;

        // 6: reset while R is pending and AW is held
        i_rReady  = 1'b0;
        i_arValid = 1'b1; i_arAddr = 12'h004;
        i_awValid = 1'b1; i_awAddr = 12'h014;
        tick;
        i_arValid = 1'b0; i_awValid = 1'b0;
        check("t6_rvalid_pre",  64'(o_rValid),  64'd1);
        check("t6_awready_pre", 64'(o_awReady), 64'd0);
        i_aReset = 1'b1;
        #1;
        check("t6_wready_in_rst", 64'(o_wReady), 64'd0);
        tick;
        i_aReset = 1'b0;
        #1;
        for (int k = 0; k < NREGS; k++) exp_regs[k] = '0;
        check("t6_rvalid",  64'(o_rValid),  64'd0);
        check("t6_bvalid",  64'(o_bValid),  64'd0);
        check("t6_rdata",   64'(o_rData),   64'd0);
        check("t6_awready", 64'(o_awReady), 64'd1);
        check_regs("t6");
        i_rReady = 1'b1;
        i_wValid = 1'b1; i_wData = 32'hCAFEF00D; i_wStrb = 4'hF;
        tick;
        i_wValid = 1'b0;
        tick; tick;
        check("t6_no_commit_bvalid", 64'(o_bValid), 64'd0);
        check("t6_no_commit_wrstb",  64'(o_wrStb),  64'd0);
        check("t6_wready_held",      64'(o_wReady), 64'd0);
        check("t6_reg5",             64'(o_regs[5*DWIDTH +: DWIDTH]), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
